// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - FIFO-fed note sequencer driving the 6-bit piano track code
// Each {duration, code} entry holds its code on track for (duration+1) beats.
module note_sequencer #(
   parameter int DEPTH    = 16,
   parameter int BEAT_DIV = 6250000,
   parameter int DUR_W    = 4
) (
   input  logic                   iFpgaClock,
   input  logic                   iFpgaReset,
   input  logic                   wr_en,
   input  logic [DUR_W+5:0]       wr_data,
   input  logic                   start,
   input  logic                   stop,
   input  logic                   clr_ovf,
   output logic [5:0]             track,
   output logic                   busy,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int BW = $clog2(BEAT_DIV);
   localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_DIV - 1);
   localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

   state_t             state_q, state_d;
   logic [DUR_W+5:0]   mem [DEPTH];
   logic [AW-1:0]      wr_ptr, rd_ptr;
   logic [BW-1:0]      beat_cnt;
   logic [DUR_W-1:0]   remaining;
   logic [DUR_W+5:0]   head;
   logic               push, pop, tick, leave_hold;

   assign head  = mem[rd_ptr];
   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);
   // full is the pre-pop occupancy, so a push in a FETCH cycle at full is dropped
   assign push  = wr_en && !full;

   always_ff @(posedge iFpgaClock or negedge iFpgaReset) begin
      if (!iFpgaReset) state_q <= IDLE;
      else             state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (stop) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (start && !empty) state_d = FETCH;
            FETCH:   state_d = HOLD;
            HOLD:    if (leave_hold) state_d = empty ? IDLE : FETCH;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      busy       = (state_q != IDLE);
      pop        = (state_q == FETCH);
      tick       = (state_q == HOLD) && (beat_cnt == BEAT_LAST);
      leave_hold = tick && (remaining == '0);
   end

   always_ff @(posedge iFpgaClock) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge iFpgaClock or negedge iFpgaReset) begin
      if (!iFpgaReset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (wr_en && full) overflow <= 1'b1;
         else if (clr_ovf)  overflow <= 1'b0;
      end
   end

   always_ff @(posedge iFpgaClock or negedge iFpgaReset) begin
      if (!iFpgaReset) begin
         beat_cnt  <= '0;
         remaining <= '0;
         track     <= 6'd0;
      end else begin
         if (stop || state_q != HOLD || tick) beat_cnt <= '0;
         else                                 beat_cnt <= beat_cnt + 1'b1;

         if (state_q == FETCH)                  remaining <= head[DUR_W+5:6];
         else if (tick && remaining != '0)      remaining <= remaining - 1'b1;

         if (stop)                              track <= 6'd0;
         else if (state_q == FETCH)             track <= head[5:0];
         else if (leave_hold && empty)          track <= 6'd0;
      end
   end

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - directed self-checking bench for note_sequencer
// Instance uses DEPTH=4, BEAT_DIV=4 so every note lasts (duration+1)*4 HOLD cycles.
module tb_note_sequencer;

   logic       clk, rst_n;
   logic       wr_en, start, stop, clr_ovf;
   logic [9:0] wr_data;
   logic [5:0] track;
   logic       busy, full, empty, overflow;
   logic [2:0] count;

   int checks   = 0;
   int failures = 0;

   note_sequencer #(.DEPTH(4), .BEAT_DIV(4), .DUR_W(4)) dut (
      .iFpgaClock(clk), .iFpgaReset(rst_n), .wr_en(wr_en), .wr_data(wr_data),
      .start(start), .stop(stop), .clr_ovf(clr_ovf), .track(track), .busy(busy),
      .full(full), .empty(empty), .count(count), .overflow(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [3:0] d, input logic [5:0] c);
      wr_en   = 1'b1;
      wr_data = {d, c};
      step();
      wr_en   = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; wr_en = 1'b0; wr_data = '0;
      start = 1'b0; stop = 1'b0; clr_ovf = 1'b0;
      step(); step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (track !== 6'd0)  begin failures++; $display("FAIL reset_track got=%0d exp=0", track); end
      checks++; if (busy !== 1'b0)   begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
      checks++; if (empty !== 1'b1)  begin failures++; $display("FAIL reset_empty got=%0b exp=1", empty); end
      checks++; if (full !== 1'b0)   begin failures++; $display("FAIL reset_full got=%0b exp=0", full); end
      checks++; if (count !== 3'd0)  begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%0b exp=0", overflow); end
   endtask

   task automatic test_reset_mid_play();
      do_reset();
      for (int k = 0; k < 4; k++) push(4'd3, 6'(40 + k));
      start = 1'b1; step(); start = 1'b0;
      step();
      checks++; if (track !== 6'd40 || count !== 3'd3) begin failures++; $display("FAIL rmid_pre track=%0d count=%0d exp 40/3", track, count); end
      step(); step();
      #2 rst_n = 1'b0;
      #1;
      checks++; if (track !== 6'd0 || busy !== 1'b0) begin failures++; $display("FAIL rmid_out track=%0d busy=%0b exp 0/0", track, busy); end
      checks++; if (count !== 3'd0 || empty !== 1'b1 || overflow !== 1'b0) begin failures++; $display("FAIL rmid_fifo count=%0d empty=%0b ovf=%0b exp 0/1/0", count, empty, overflow); end
      @(posedge clk); #1 rst_n = 1'b1;
      step();
   endtask

   task automatic test_basic_play();
      logic [5:0] exp;
      do_reset();
      push(4'd1, 6'd12);
      push(4'd0, 6'd20);
      start = 1'b1; step(); start = 1'b0;
      checks++; if (busy !== 1'b1 || track !== 6'd0) begin failures++; $display("FAIL play_fetch busy=%0b track=%0d exp 1/0", busy, track); end
      for (int i = 1; i <= 14; i++) begin
         step();
         exp = (i <= 9) ? 6'd12 : (i <= 13) ? 6'd20 : 6'd0;
         checks++; if (track !== exp) begin failures++; $display("FAIL play_track cyc=%0d got=%0d exp=%0d", i, track, exp); end
      end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL play_done_busy got=%0b exp=0", busy); end
   endtask

   task automatic test_full_overflow();
      logic [5:0] got [8];
      logic [5:0] last;
      int n;
      do_reset();
      for (int k = 1; k <= 5; k++) begin
         push(4'd0, 6'(k));
         if (k == 4) begin
            checks++; if (full !== 1'b1) begin failures++; $display("FAIL ovf_full4 got=%0b exp=1", full); end
         end
      end
      checks++; if (overflow !== 1'b1 || count !== 3'd4) begin failures++; $display("FAIL ovf_set ovf=%0b count=%0d exp 1/4", overflow, count); end
      clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clr got=%0b exp=0", overflow); end
      start = 1'b1; step(); start = 1'b0;
      n = 0; last = 6'd0;
      for (int cyc = 0; cyc < 200; cyc++) begin
         step();
         if (track != 6'd0 && track != last && n < 8) begin got[n] = track; n++; end
         if (track != 6'd0) last = track;
         if (!busy) break;
      end
      checks++; if (n != 4 || busy !== 1'b0) begin failures++; $display("FAIL ovf_play_len got=%0d exp=4 busy=%0b", n, busy); end
      for (int i = 0; i < 4 && i < n; i++) begin
         checks++; if (got[i] !== 6'(i + 1)) begin failures++; $display("FAIL ovf_play_code idx=%0d got=%0d exp=%0d", i, got[i], i + 1); end
      end
   endtask

   task automatic test_push_pop_full();
      do_reset();
      for (int k = 7; k <= 10; k++) push(4'd0, 6'(k));
      start = 1'b1; step(); start = 1'b0;
      wr_en = 1'b1; wr_data = {4'd0, 6'd11};
      step();
      wr_en = 1'b0;
      checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ppf_ovf got=%0b exp=1", overflow); end
      checks++; if (count !== 3'd3) begin failures++; $display("FAIL ppf_count got=%0d exp=3", count); end
      checks++; if (track !== 6'd7) begin failures++; $display("FAIL ppf_track got=%0d exp=7", track); end
   endtask

   task automatic test_stop_mid_note();
      do_reset();
      push(4'd2, 6'd30); push(4'd1, 6'd31); push(4'd0, 6'd32);
      start = 1'b1; step(); start = 1'b0;
      step(); step(); step();
      stop = 1'b1; step(); stop = 1'b0;
      checks++; if (track !== 6'd0 || busy !== 1'b0) begin failures++; $display("FAIL stop_out track=%0d busy=%0b exp 0/0", track, busy); end
      checks++; if (count !== 3'd2) begin failures++; $display("FAIL stop_count got=%0d exp=2", count); end
      start = 1'b1; step(); start = 1'b0;
      checks++; if (track !== 6'd0) begin failures++; $display("FAIL stop_refetch got=%0d exp=0", track); end
      for (int i = 0; i < 9; i++) begin
         step();
         checks++; if (track !== 6'd31) begin failures++; $display("FAIL stop_resume cyc=%0d got=%0d exp=31", i, track); end
      end
      step();
      checks++; if (track !== 6'd32) begin failures++; $display("FAIL stop_next got=%0d exp=32", track); end
   endtask

   task automatic test_start_empty();
      do_reset();
      start = 1'b1; step(); step(); step();
      checks++; if (busy !== 1'b0 || track !== 6'd0 || empty !== 1'b1) begin failures++; $display("FAIL empty_start busy=%0b track=%0d empty=%0b exp 0/0/1", busy, track, empty); end
      start = 1'b0;
   endtask

   task automatic test_wrap();
      logic [5:0] got [11];
      logic [5:0] last;
      int n;
      do_reset();
      n = 0; last = 6'd0;
      start = 1'b1;
      fork
         begin
            int k = 1;
            for (int cyc = 0; cyc < 400 && k <= 11; cyc++) begin
               if (!full) begin wr_en = 1'b1; wr_data = {4'd0, 6'(k)}; k++; end
               else wr_en = 1'b0;
               step();
            end
            wr_en = 1'b0;
         end
         begin
            for (int cyc = 0; cyc < 600 && n < 11; cyc++) begin
               step();
               if (track != 6'd0 && track != last) begin got[n] = track; n++; end
               if (track != 6'd0) last = track;
            end
         end
      join
      start = 1'b0;
      for (int cyc = 0; cyc < 50 && busy; cyc++) step();
      checks++; if (n != 11) begin failures++; $display("FAIL wrap_len got=%0d exp=11", n); end
      for (int i = 0; i < n; i++) begin
         checks++; if (got[i] !== 6'(i + 1)) begin failures++; $display("FAIL wrap_code idx=%0d got=%0d exp=%0d", i, got[i], i + 1); end
      end
      checks++; if (overflow !== 1'b0 || empty !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL wrap_end ovf=%0b empty=%0b busy=%0b exp 0/1/0", overflow, empty, busy); end
   endtask

   initial begin
      test_reset();
      test_reset_mid_play();
      test_basic_play();
      test_full_overflow();
      test_push_pop_full();
      test_stop_mid_note();
      test_start_empty();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
